data_mem_write_buffer: RTL and testbench

- Sits directly downstream of the data cache, between it and main data memory.
- Absorbs write-through stores in a small FIFO and drains them to memory in the background.
- Services cache read misses: drains pending stores first, fetches the word, returns it to the processor and pushes it into the cache as a refill.
- Stalls the pipeline only on buffer-full or read-miss.

---
 rtl/dmem_pkg.sv | 22 ++
 rtl/wb_store_fifo.sv | 51 +++++
 rtl/data_mem_write_buffer.sv | 142 ++++++++++++++
 tb/tb_data_mem_write_buffer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory write buffer: FSM states,
// default sizes and the buffered store entry.
package dmem_pkg;

  localparam int DMEM_DEPTH  = 4;
  localparam int DMEM_ADDR_W = 32;
  localparam int DMEM_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    RD_WAIT_DRAIN,
    RD_REQ,
    RD_DONE
  } state_t;

  typedef struct packed {
    logic [DMEM_ADDR_W-1:0] addr;
    logic [DMEM_DATA_W-1:0] data;
  } store_t;

endpackage

// File: rtl/wb_store_fifo.sv
// Store FIFO for the write buffer: synchronous, sync reset.
// Ports: push_i/din_i in, pop_i/dout_o out, full_o, empty_o, count_o.
module wb_store_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [W-1:0]             din_i,
  input  logic                     pop_i,
  output logic [W-1:0]             dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rp_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + 1'b1;
      if (do_pop)  rp_q <= rp_q + 1'b1;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset; only pointers/count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= din_i;
  end

endmodule

// File: rtl/data_mem_write_buffer.sv
// Write buffer between data cache and memory: buffers stores,
// drains them in order, and services read misses behind them.
// Ports: cpu_* from MEM stage, stall/rd/refill back, mem_* handshake.
module data_mem_write_buffer
  import dmem_pkg::*;
#(
  parameter int DEPTH  = DMEM_DEPTH,
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_memwrite,
  input  logic              cpu_memread,
  input  logic              cache_hit,
  output logic              stall,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              rd_valid,
  output logic              refill_valid,
  output logic [ADDR_W-4:0] refill_addr,
  output logic [DATA_W-1:0] refill_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic          push, pop;
  logic          full, empty, last;
  logic [CW-1:0] count;
  store_t        push_ent, head;
  logic          miss, wr_stall, rd_done;

  assign push_ent = '{addr: cpu_addr, data: cpu_wdata};

  wb_store_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(store_t))
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .din_i   (push_ent),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  assign last = (count == CW'(1));

  // A simultaneous read+write request is treated as a write.
  assign miss = cpu_memread & ~cpu_memwrite & ~cache_hit &
                ((state_q == IDLE) | (state_q == WR_REQ));

  assign wr_stall = cpu_memwrite & full;

  assign stall = wr_stall | miss |
                 (state_q == RD_WAIT_DRAIN) |
                 (state_q == RD_REQ);

  assign push = cpu_memwrite & ~stall;

  always_comb begin
    state_d   = state_q;
    rdata_d   = rdata_q;
    pop       = 1'b0;
    rd_done   = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_q)
      IDLE: begin
        if (miss)
          state_d = empty ? RD_REQ : RD_WAIT_DRAIN;
        else if (!empty)
          state_d = WR_REQ;
      end
      WR_REQ: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = head.addr;
        mem_wdata = head.data;
        pop       = mem_ack;
        if (miss)
          state_d = (mem_ack && last) ? RD_REQ : RD_WAIT_DRAIN;
        else if (mem_ack && last)
          state_d = IDLE;
      end
      RD_WAIT_DRAIN: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = head.addr;
        mem_wdata = head.data;
        pop       = mem_ack;
        if (mem_ack && last)
          state_d = RD_REQ;
      end
      RD_REQ: begin
        mem_req  = 1'b1;
        mem_addr = cpu_addr;
        if (mem_ack) begin
          rdata_d = mem_rdata;
          state_d = RD_DONE;
        end
      end
      RD_DONE: begin
        rd_done = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

  assign rd_valid     = rd_done;
  assign refill_valid = rd_done;
  assign cpu_rdata    = rd_done ? rdata_q : '0;
  assign refill_data  = rd_done ? rdata_q : '0;
  assign refill_addr  = rd_done ? cpu_addr[ADDR_W-1:3] : '0;

endmodule

// File: tb/tb_data_mem_write_buffer.sv
// Directed bench for data_mem_write_buffer.
// Hand-computed expectations, immediate assertions per check.
module tb_data_mem_write_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_memwrite, cpu_memread, cache_hit;
  logic        stall, rd_valid, refill_valid;
  logic [31:0] cpu_rdata, refill_data;
  logic [28:0] refill_addr;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_mem_write_buffer dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_memwrite (cpu_memwrite),
    .cpu_memread  (cpu_memread),
    .cache_hit    (cache_hit),
    .stall        (stall),
    .cpu_rdata    (cpu_rdata),
    .rd_valid     (rd_valid),
    .refill_valid (refill_valid),
    .refill_addr  (refill_addr),
    .refill_data  (refill_data),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata)
  );

  always @(posedge clk)
    assert (!(cpu_memread && cpu_memwrite))
      else $error("illegal stimulus: memread and memwrite both set");

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_in();
    cpu_addr     = '0;
    cpu_wdata    = '0;
    cpu_memwrite = 1'b0;
    cpu_memread  = 1'b0;
    cache_hit    = 1'b0;
    mem_ack      = 1'b0;
    mem_rdata    = '0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    cpu_memwrite = 1'b1;
    cpu_addr     = a;
    cpu_wdata    = d;
  endtask

  task automatic chk_wr(input string tag, input logic [31:0] a,
                        input logic [31:0] d);
    chk({tag, "_req"}, 64'(mem_req), 64'd1);
    chk({tag, "_we"}, 64'(mem_we), 64'd1);
    chk({tag, "_addr"}, 64'(mem_addr), 64'(a));
    chk({tag, "_wdata"}, 64'(mem_wdata), 64'(d));
  endtask

  initial begin
    idle_in();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_req", 64'(mem_req), 64'd0);
    chk("rst_rdv", 64'(rd_valid), 64'd0);
    chk("rst_refv", 64'(refill_valid), 64'd0);
    chk("rst_rdata", 64'(cpu_rdata), 64'd0);
    chk("rst_cnt", 64'(dut.count), 64'd0);

    // Single store
    store(32'h28, 32'hDEADBEEF);
    #1 chk("s1_stall", 64'(stall), 64'd0);
    tick();
    idle_in();
    #1 chk("s1_noreq", 64'(mem_req), 64'd0);
    tick();
    #1 chk_wr("s1_a", 32'h28, 32'hDEADBEEF);
    tick();
    #1 chk_wr("s1_b", 32'h28, 32'hDEADBEEF);
    mem_ack = 1'b1;
    #1 chk_wr("s1_c", 32'h28, 32'hDEADBEEF);
    tick();
    mem_ack = 1'b0;
    #1 chk("s1_done_req", 64'(mem_req), 64'd0);
    chk("s1_cnt", 64'(dut.count), 64'd0);
    tick();

    // Fill: five stores, no ack
    for (int i = 0; i < 4; i++) begin
      store(32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
      #1 chk("fill_nostall", 64'(stall), 64'd0);
      tick();
    end
    store(32'h110, 32'hA4);
    #1 chk("fill_stall5", 64'(stall), 64'd1);
    chk("fill_cnt", 64'(dut.count), 64'd4);
    chk_wr("fill_head", 32'h100, 32'hA0);
    tick();
    #1 chk("fill_stall5b", 64'(stall), 64'd1);
    mem_ack = 1'b1;
    #1 chk("fill_stall_ack", 64'(stall), 64'd1);
    tick();
    mem_ack = 1'b0;
    #1 chk("fill_unstall", 64'(stall), 64'd0);
    chk("fill_cnt3", 64'(dut.count), 64'd3);
    tick();
    cpu_memwrite = 1'b0;
    #1 chk("fill_cnt4", 64'(dut.count), 64'd4);
    for (int i = 1; i < 5; i++) begin
      chk_wr("fill_drain", 32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      #1;
    end
    chk("fill_idle", 64'(mem_req), 64'd0);
    chk("fill_empty", 64'(dut.count), 64'd0);
    idle_in();
    tick();

    // Read miss with empty FIFO
    cpu_memread = 1'b1;
    cpu_addr    = 32'h40;
    #1 chk("rm_stall0", 64'(stall), 64'd1);
    chk("rm_noreq0", 64'(mem_req), 64'd0);
    tick();
    #1 chk("rm_stall1", 64'(stall), 64'd1);
    chk("rm_req", 64'(mem_req), 64'd1);
    chk("rm_we", 64'(mem_we), 64'd0);
    chk("rm_addr", 64'(mem_addr), 64'h40);
    tick();
    #1 chk("rm_stall2", 64'(stall), 64'd1);
    tick();
    mem_ack   = 1'b1;
    mem_rdata = 32'h12345678;
    #1 chk("rm_stall3", 64'(stall), 64'd1);
    chk("rm_rdv_early", 64'(rd_valid), 64'd0);
    tick();
    mem_ack   = 1'b0;
    mem_rdata = '0;
    #1 chk("rm_done_stall", 64'(stall), 64'd0);
    chk("rm_rdv", 64'(rd_valid), 64'd1);
    chk("rm_refv", 64'(refill_valid), 64'd1);
    chk("rm_refaddr", 64'(refill_addr), 64'h8);
    chk("rm_rdata", 64'(cpu_rdata), 64'h12345678);
    chk("rm_refdata", 64'(refill_data), 64'h12345678);
    chk("rm_done_noreq", 64'(mem_req), 64'd0);
    tick();
    idle_in();
    #1 chk("rm_rdv_off", 64'(rd_valid), 64'd0);

    // Read miss behind two buffered stores
    store(32'h40, 32'h11111111);
    tick();
    store(32'h44, 32'h22222222);
    tick();
    idle_in();
    cpu_memread = 1'b1;
    cpu_addr    = 32'h40;
    #1 chk("rd2_stall", 64'(stall), 64'd1);
    chk_wr("rd2_w0", 32'h40, 32'h11111111);
    tick();
    #1 chk("rd2_drain_stall", 64'(stall), 64'd1);
    chk_wr("rd2_w0b", 32'h40, 32'h11111111);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    #1 chk_wr("rd2_w1", 32'h44, 32'h22222222);
    chk("rd2_stall_w1", 64'(stall), 64'd1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    #1 chk("rd2_rreq", 64'(mem_req), 64'd1);
    chk("rd2_rwe", 64'(mem_we), 64'd0);
    chk("rd2_raddr", 64'(mem_addr), 64'h40);
    mem_ack   = 1'b1;
    mem_rdata = 32'h11111111;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = '0;
    #1 chk("rd2_rdv", 64'(rd_valid), 64'd1);
    chk("rd2_rdata", 64'(cpu_rdata), 64'h11111111);
    chk("rd2_stall_done", 64'(stall), 64'd0);
    tick();
    idle_in();

    // Read hit while three stores drain
    for (int i = 0; i < 3; i++) begin
      store(32'h200 + 32'(4 * i), 32'hB0 + 32'(i));
      tick();
    end
    idle_in();
    cpu_memread = 1'b1;
    cache_hit   = 1'b1;
    cpu_addr    = 32'h300;
    for (int i = 0; i < 3; i++) begin
      #1 chk("hit_stall", 64'(stall), 64'd0);
      chk("hit_rdv", 64'(rd_valid), 64'd0);
      chk_wr("hit_drain", 32'h200 + 32'(4 * i), 32'hB0 + 32'(i));
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
    end
    #1 chk("hit_idle", 64'(mem_req), 64'd0);
    chk("hit_empty", 64'(dut.count), 64'd0);
    idle_in();
    tick();

    // Reset during RD_REQ
    cpu_memread = 1'b1;
    cpu_addr    = 32'h80;
    tick();
    #1 chk("rr_req", 64'(mem_req), 64'd1);
    chk("rr_we", 64'(mem_we), 64'd0);
    idle_in();
    reset = 1'b1;
    tick();
    #1 chk("rr_req0", 64'(mem_req), 64'd0);
    chk("rr_stall0", 64'(stall), 64'd0);
    chk("rr_addr0", 64'(mem_addr), 64'd0);
    chk("rr_cnt0", 64'(dut.count), 64'd0);
    reset     = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'hCAFEF00D;
    tick();
    idle_in();
    #1 chk("rr_late_rdv", 64'(rd_valid), 64'd0);
    chk("rr_late_refv", 64'(refill_valid), 64'd0);
    chk("rr_late_req", 64'(mem_req), 64'd0);
    chk("rr_late_rdata", 64'(cpu_rdata), 64'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
